// File: rtl/hlsm_launcher.sv
// Launcher that hands one operand triple to a downstream HLSM, waits for CEnd and presents the results.
// Optional watchdog on the WAIT state is enabled with `define HLSM_LAUNCH_TIMEOUT_EN.
module hlsm_launcher #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [DATA_W-1:0] in_c,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] c,
    output logic              CStart,
    input  logic              CEnd,
    input  logic [DATA_W-1:0] z_in,
    input  logic [DATA_W-1:0] x_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_z,
    output logic [DATA_W-1:0] out_x,
    output logic              Error,
    input  logic              ErrorRst
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_HOLD,
        S_ERR
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   a_q, a_d, b_q, b_d, c_q, c_d;
    logic [DATA_W-1:0]   z_q, z_d, x_q, x_d;
    logic                accept;

    assign accept = in_valid && (state_q == S_IDLE);

    // NOTE: every signal gets its hold value first, so no path through the case leaves one unassigned (no latches).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        z_d     = z_q;
        x_d     = x_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    c_d     = in_c;
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // CEnd wins over an expiring watchdog in the same cycle.
                if (CEnd) begin
                    z_d     = z_in;
                    x_d     = x_in;
                    state_d = S_HOLD;
                end else begin
                    if (cnt_q != CNT_W'(TIMEOUT)) cnt_d = cnt_q + 1'b1;
`ifdef HLSM_LAUNCH_TIMEOUT_EN
                    if (cnt_q == CNT_W'(TIMEOUT - 1)) state_d = S_ERR;
`endif
                end
            end
            S_HOLD: begin
                if (out_ready) state_d = S_IDLE;
            end
            S_ERR: begin
`ifdef HLSM_LAUNCH_TIMEOUT_EN
                if (ErrorRst) state_d = S_IDLE;
`else
                state_d = S_IDLE;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments; the data registers are reset too so a/b/c and
    // out_z/out_x read as zero after Rst.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            z_q     <= '0;
            x_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            z_q     <= z_d;
            x_q     <= x_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign CStart    = (state_q == S_LAUNCH);
    assign out_valid = (state_q == S_HOLD);
    assign a         = a_q;
    assign b         = b_q;
    assign c         = c_q;
    assign out_z     = z_q;
    assign out_x     = x_q;

`ifdef HLSM_LAUNCH_TIMEOUT_EN
    // ERR is only left through ErrorRst, so the flag is sticky by construction.
    assign Error = (state_q == S_ERR);
`else
    logic unused_error_rst;
    assign unused_error_rst = ErrorRst;
    assign Error            = 1'b0;
`endif

endmodule

// File: tb/tb_hlsm_launcher.sv
// Self-checking bench for hlsm_launcher: directed scenarios plus randomized transactions against a
// transaction-level model (latency, operand/result values, handshake levels).
module tb_hlsm_launcher;

    localparam int DW = 32;
    localparam int TO = 8;

    logic          Clk = 1'b0;
    logic          Rst, in_valid, in_ready, CStart, CEnd, out_valid, out_ready, Error, ErrorRst;
    logic [DW-1:0] in_a, in_b, in_c, a, b, c, z_in, x_in, out_z, out_x;

    int n_checks = 0;
    int n_errors = 0;

    // Model: what a/b/c and out_z/out_x must currently hold.
    logic [DW-1:0] exp_a = '0, exp_b = '0, exp_c = '0, exp_z = '0, exp_x = '0;

    hlsm_launcher #(.DATA_W(DW), .TIMEOUT(TO)) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_c     (in_c),
        .a        (a),
        .b        (b),
        .c        (c),
        .CStart   (CStart),
        .CEnd     (CEnd),
        .z_in     (z_in),
        .x_in     (x_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_z    (out_z),
        .out_x    (out_x),
        .Error    (Error),
        .ErrorRst (ErrorRst)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_ops(input string tag);
        check({tag, "_a"}, a, exp_a);
        check({tag, "_b"}, b, exp_b);
        check({tag, "_c"}, c, exp_c);
    endtask

    task automatic check_res(input string tag);
        check({tag, "_z"}, out_z, exp_z);
        check({tag, "_x"}, out_x, exp_x);
    endtask

    // Idle cycles with CEnd noise, which IDLE must ignore.
    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge Clk);
            check("idle_ready", in_ready, 1'b1);
            check("idle_cstart", CStart, 1'b0);
            check("idle_valid", out_valid, 1'b0);
            check_res("idle_res");
            in_valid = 1'b0;
            CEnd     = 1'($urandom_range(0, 1));
            z_in     = $urandom;
            x_in     = $urandom;
        end
    endtask

    // One full transaction: accept, launch, CEnd after 'delay' WAIT cycles, hold for 'hold' stalled cycles.
    task automatic run_txn(input logic [DW-1:0] oa, input logic [DW-1:0] ob, input logic [DW-1:0] oc,
                           input int delay, input int hold,
                           input logic [DW-1:0] rz, input logic [DW-1:0] rx);
        @(negedge Clk);
        check("txn_ready", in_ready, 1'b1);
        in_valid = 1'b1;
        in_a     = oa;
        in_b     = ob;
        in_c     = oc;
        CEnd     = 1'($urandom_range(0, 1));
        z_in     = $urandom;
        x_in     = $urandom;

        @(negedge Clk);
        exp_a = oa;
        exp_b = ob;
        exp_c = oc;
        check("launch_cstart", CStart, 1'b1);
        check("launch_ready", in_ready, 1'b0);
        check_ops("launch");
        in_valid = 1'b0;
        in_a     = $urandom;
        in_b     = $urandom;
        in_c     = $urandom;
        CEnd     = 1'($urandom_range(0, 1));
        z_in     = $urandom;
        x_in     = $urandom;

        for (int k = 0; k <= delay; k++) begin
            @(negedge Clk);
            check("wait_cstart", CStart, 1'b0);
            check("wait_valid", out_valid, 1'b0);
            check("wait_ready", in_ready, 1'b0);
            check("wait_error", Error, 1'b0);
            check_ops("wait");
            in_valid = 1'($urandom_range(0, 1));
            if (k == delay) begin
                CEnd = 1'b1;
                z_in = rz;
                x_in = rx;
            end else begin
                CEnd = 1'b0;
                z_in = $urandom;
                x_in = $urandom;
            end
        end

        @(negedge Clk);
        exp_z = rz;
        exp_x = rx;
        for (int h = 0; h <= hold; h++) begin
            if (h > 0) @(negedge Clk);
            check("hold_valid", out_valid, 1'b1);
            check("hold_ready", in_ready, 1'b0);
            check("hold_cstart", CStart, 1'b0);
            check("hold_error", Error, 1'b0);
            check_res("hold");
            check_ops("hold");
            out_ready = (h == hold);
            in_valid  = 1'($urandom_range(0, 1));
            CEnd      = 1'($urandom_range(0, 1));
            z_in      = $urandom;
            x_in      = $urandom;
        end

        @(negedge Clk);
        check("done_valid", out_valid, 1'b0);
        check("done_ready", in_ready, 1'b1);
        check_res("done");
        out_ready = 1'b0;
        in_valid  = 1'b0;
        CEnd      = 1'b0;
    endtask

    initial begin
        Rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_c      = '0;
        CEnd      = 1'b0;
        z_in      = '0;
        x_in      = '0;
        out_ready = 1'b0;
        ErrorRst  = 1'b0;

        repeat (2) @(negedge Clk);
        check("rst_ready", in_ready, 1'b1);
        check("rst_cstart", CStart, 1'b0);
        check("rst_valid", out_valid, 1'b0);
        check("rst_error", Error, 1'b0);
        check_ops("rst");
        check_res("rst");
        Rst = 1'b0;

        // Basic transaction with minimum latency, then a stalled HOLD.
        run_txn(32'd5, 32'd7, 32'd3, 0, 0, 32'd20, 32'd3);
        run_txn(32'd11, 32'd12, 32'd13, 1, 4, 32'hDEAD_BEEF, 32'h1234_5678);

        // Reset in the middle of WAIT, followed by a late CEnd.
        @(negedge Clk);
        in_valid = 1'b1;
        in_a     = 32'hA1;
        in_b     = 32'hB2;
        in_c     = 32'hC3;
        @(negedge Clk);
        in_valid = 1'b0;
        repeat (2) @(negedge Clk);
        check("mid_wait_ready", in_ready, 1'b0);
        Rst = 1'b1;
        @(negedge Clk);
        exp_a = '0;
        exp_b = '0;
        exp_c = '0;
        exp_z = '0;
        exp_x = '0;
        check("wrst_ready", in_ready, 1'b1);
        check("wrst_cstart", CStart, 1'b0);
        check("wrst_valid", out_valid, 1'b0);
        check_ops("wrst");
        check_res("wrst");
        Rst  = 1'b0;
        CEnd = 1'b1;
        z_in = 32'h5555;
        x_in = 32'h6666;
        @(negedge Clk);
        check("late_cend_valid", out_valid, 1'b0);
        check("late_cend_ready", in_ready, 1'b1);
        check_res("late_cend");
        CEnd = 1'b0;

        // Reset has priority over a simultaneous in_valid.
        Rst      = 1'b1;
        in_valid = 1'b1;
        in_a     = 32'h77;
        @(negedge Clk);
        check("rst_prio_ready", in_ready, 1'b1);
        check("rst_prio_cstart", CStart, 1'b0);
        check("rst_prio_a", a, 32'h0);
        Rst      = 1'b0;
        in_valid = 1'b0;

`ifdef HLSM_LAUNCH_TIMEOUT_EN
        // CEnd on the expiry cycle is captured and raises no error.
        run_txn(32'h1, 32'h2, 32'h3, TO - 1, 1, 32'hCAFE, 32'hF00D);

        // Watchdog expiry.
        @(negedge Clk);
        in_valid = 1'b1;
        in_a     = 32'h9;
        in_b     = 32'h8;
        in_c     = 32'h7;
        @(negedge Clk);
        in_valid = 1'b0;
        for (int k = 0; k < TO; k++) begin
            @(negedge Clk);
            check("to_wait_error", Error, 1'b0);
            check("to_wait_ready", in_ready, 1'b0);
            CEnd = 1'b0;
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            check("to_error", Error, 1'b1);
            check("to_ready", in_ready, 1'b0);
            check("to_valid", out_valid, 1'b0);
            check_res("to");
            CEnd     = 1'b1;
            in_valid = 1'b1;
        end
        CEnd     = 1'b0;
        in_valid = 1'b0;
        ErrorRst = 1'b1;
        @(negedge Clk);
        ErrorRst = 1'b0;
        check("erst_error", Error, 1'b0);
        check("erst_ready", in_ready, 1'b1);
`else
        // Without the watchdog WAIT holds for as long as CEnd takes.
        run_txn(32'h1, 32'h2, 32'h3, 200, 0, 32'hCAFE, 32'hF00D);
`endif

        for (int t = 0; t < 40; t++) begin
            int max_delay;
`ifdef HLSM_LAUNCH_TIMEOUT_EN
            max_delay = TO - 1;
`else
            max_delay = 12;
`endif
            idle_cycles($urandom_range(0, 2));
            run_txn($urandom, $urandom, $urandom, $urandom_range(0, max_delay), $urandom_range(0, 3),
                    $urandom, $urandom);
        end
        idle_cycles(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hlsm_launcher.md
HLSM_LAUNCHER -- requirements
Module: hlsm_launcher

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/result width.
REQ-002 SHALL have parameter TIMEOUT, default 64, maximum WAIT cycles before error (used only with REQ-031).
REQ-003 SHALL have Clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have Rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have in_valid  input  1, in_ready  output  1  operand-triple handshake.
REQ-006 SHALL have in_a, in_b, in_c  input  DATA_W  operands, sampled on accept.
REQ-007 SHALL have a, b, c  output  DATA_W  registered operands driven to downstream HLSM.
REQ-008 SHALL have CStart  output  1  single-cycle start pulse to downstream HLSM.
REQ-009 SHALL have CEnd  input  1  downstream done indication.
REQ-010 SHALL have z_in, x_in  input  DATA_W  downstream results, valid while CEnd=1.
REQ-011 SHALL have out_valid  output  1, out_ready  input  1  result handshake.
REQ-012 SHALL have out_z, out_x  output  DATA_W  captured results.
REQ-013 SHALL have Error  output  1 sticky timeout flag; ErrorRst  input  1 clears it.

Function
REQ-014 SHALL implement states IDLE, LAUNCH, WAIT, HOLD, ERR.
REQ-015 in_ready SHALL be 1 only in IDLE; accept = in_valid & in_ready.
REQ-016 IDLE: on accept, SHALL latch in_a/in_b/in_c into a/b/c and go to LAUNCH.
REQ-017 LAUNCH: CStart SHALL be 1 for exactly this one cycle; next state WAIT.
REQ-018 a/b/c SHALL stay stable from LAUNCH until return to IDLE.
REQ-019 CEnd SHALL be sampled only in WAIT; CEnd in IDLE, LAUNCH, HOLD, ERR ignored.
REQ-020 WAIT with CEnd=1: SHALL latch z_in/x_in into out_z/out_x and go to HOLD.
REQ-021 HOLD: out_valid SHALL be 1; on out_ready=1 go to IDLE; out_z/out_x unchanged until next capture.
REQ-022 Minimum latency: accept at cycle N -> CStart at N+1 -> CEnd earliest at N+2 -> out_valid at N+3.
REQ-023 Single outstanding transaction; no new accept until HOLD completes.
REQ-024 WAIT cycle counter SHALL be ceil(log2(TIMEOUT+1)) bits, cleared on entering WAIT, saturating.
REQ-025 No arithmetic on data; values pass through unmodified at DATA_W.

Reset
REQ-026 Rst=1 SHALL force IDLE in the next cycle regardless of current state, including mid-WAIT.
REQ-027 Reset values: CStart=0, out_valid=0, Error=0, a=b=c=0, out_z=out_x=0, counter=0; in_ready=1 after reset.
REQ-028 Rst SHALL take priority over in_valid, CEnd, ErrorRst.

Configuration
REQ-029 Macro HLSM_LAUNCH_TIMEOUT_EN SHALL select the watchdog.
REQ-030 Without macro: WAIT holds indefinitely until CEnd; Error tied 0; ErrorRst ignored; ERR unreachable.
REQ-031 With macro: counter reaching TIMEOUT in WAIT without CEnd SHALL go to ERR and set Error=1.
REQ-032 With macro: CEnd=1 in the same cycle the counter reaches TIMEOUT SHALL take precedence (capture, go to HOLD, no error).
REQ-033 With macro: ERR holds in_ready=0, out_valid=0 until ErrorRst=1, then Error=0 and IDLE next cycle.

Verification
REQ-034 Rst then in_a=5,in_b=7,in_c=3, in_valid 1 cycle; CEnd next cycle after CStart with z_in=20,x_in=3 -> CStart one cycle, out_valid=1 with out_z=20,out_x=3 at accept+3.
REQ-035 out_ready held 0 for 4 cycles in HOLD -> out_valid stays 1, out_z/out_x stable, in_ready=0; release -> IDLE, in_ready=1.
REQ-036 Rst asserted during WAIT -> next cycle IDLE, CStart=0, out_valid=0, a=b=c=0; late CEnd ignored.
REQ-037 Macro on, TIMEOUT=8, CEnd never asserted -> Error=1 after 8 WAIT cycles; ErrorRst pulse -> Error=0, in_ready=1.
REQ-038 Macro on, TIMEOUT=8, CEnd exactly on the expiry cycle -> Error stays 0, results captured.
REQ-039 Macro off, CEnd delayed 200 cycles -> no error, results captured normally.
